serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that sequences a single 1-bit `full_adder` instance over WIDTH cycles to add two WIDTH-bit operands plus carry-in. It accepts operands on a valid/ready input handshake, feeds one bit pair per clock LSB-first through the full adder while holding the carry in a flop, and returns a sum and carry-out on a valid/ready output handshake. It trades WIDTH cycles of latency for one full-adder cell of arithmetic area. It sits between an operand producer and a result consumer in the arithmetic datapath.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  controller can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum/cout valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits [WIDTH-1:0]
- cout  output  1  result carry-out
- busy  output  1  high in RUN or DONE

## Operation
- Datapath: one `full_adder` instance (ports A, B, C, S, Co). A=a_sh[0], B=b_sh[0], C=carry flop. No other adder in the block.
- Registers: a_sh, b_sh, s_sh (WIDTH each), carry (1), bit counter (enough bits to hold WIDTH), result regs sum/cout, state.
- IDLE: in_ready=1. On in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=cin, count<=0, go RUN.
- RUN: each edge: a_sh, b_sh shift right 1; s_sh<={S, s_sh[WIDTH-1:1]}; carry<=Co; count<=count+1. On the edge where count==WIDTH-1: load sum<={S, s_sh[WIDTH-1:1]} and cout<=Co, then go DONE.
- DONE: out_valid=1; sum/cout held stable. On out_valid&&out_ready go IDLE.
- Arithmetic: {cout,sum} == a + b + cin exactly (WIDTH+1 bits, no overflow loss).
- sum/cout change only on the load edge. They hold the last result through IDLE and RUN.
- in_valid while not IDLE is ignored. a/b/cin are sampled only on the accept edge and are don't-care afterwards.
- out_ready outside DONE is ignored.
- Reset in any state: next state IDLE, counter 0, carry 0, shift regs 0, sum=0, cout=0. An in-flight operation is aborted and no out_valid is ever produced for it.
- rst has priority over simultaneous in_valid or out_ready handshakes.

## Timing
- Reset values (after rst edge): in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- in_ready, out_valid and busy decode directly from the state register; no combinational path from inputs.
- Latency: accept on edge E0. RUN covers edges E1..E(WIDTH). out_valid is high in the cycle after edge E(WIDTH).
- With out_ready=1, the output handshake occurs on E(WIDTH+1) and in_ready is high after it. The next accept is at E(WIDTH+2).
- Minimum initiation interval: WIDTH+2 cycles.
- Backpressure: with out_ready=0, DONE persists indefinitely with outputs stable.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, sum=0, cout=0; no operand accepted during reset.
- Basic/latency (WIDTH=8): a=8'h00, b=8'h00, cin=0 → out_valid high exactly after 8 RUN edges, sum=8'h00, cout=0. Then a=8'h03, b=8'h05, cin=1 → sum=8'h09, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → out_valid, sum, cout stable and in_ready=0. Release out_ready → IDLE next cycle, then the new operands are accepted.
- Reset mid-RUN: assert rst after the 4th RUN edge → IDLE next cycle with no out_valid. Then a=8'h5A, b=8'hA5, cin=1 → sum=8'h00, cout=1.
- Streaming: tie in_valid=out_ready=1 and apply 1000 random operands per WIDTH∈{2,8,32} → accepts spaced exactly WIDTH+2 cycles; every {cout,sum} matches a+b+cin.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in
//   on a valid/ready handshake, walks them LSB-first through a single 1-bit
//   full adder over WIDTH clock cycles, and presents {cout, sum} on a second
//   valid/ready handshake. This costs WIDTH cycles of latency but needs only
//   one full-adder cell of arithmetic.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a, b, cin are valid
//   in_ready   controller can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum/cout are valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, held until the next result is loaded
//   cout       carry-out, held with sum
//   busy       high while an operation is in RUN or DONE

// One-bit full adder: the only arithmetic cell in the controller.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ C;
  assign Co = (A & B) | (C & (A ^ B));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // The counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sShift_q, sShift_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             faSum;
  logic             faCarry;
  logic [WIDTH-1:0] sShiftNext;

  // The lowest sum-shift bit is always shifted out before it can reach the
  // result, so it is intentionally left unread.
  logic             unusedShiftLsb;
  assign unusedShiftLsb = sShift_q[0];

  full_adder uFullAdder (
    .A  (aShift_q[0]),
    .B  (bShift_q[0]),
    .C  (carry_q),
    .S  (faSum),
    .Co (faCarry)
  );

  // New sum bits enter at the MSB, so after WIDTH shifts bit 0 of the
  // operands has landed at bit 0 of the result.
  assign sShiftNext = {faSum, sShift_q[WIDTH-1:1]};

  // Next-state logic. sum/cout only change on the final RUN edge so the
  // previous result stays visible through IDLE and the next RUN.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    sShift_d = sShift_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aShift_d = a;
          bShift_d = b;
          carry_d  = cin;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        sShift_d = sShiftNext;
        carry_d  = faCarry;
        count_d  = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          sum_d   = sShiftNext;
          cout_d  = faCarry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over any handshake and aborts an in-flight
  // operation without ever raising out_valid for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      sShift_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      sShift_q <= sShift_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Handshake flags decode straight from the state register, so there is
  // no combinational path from any input to them.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl. A WIDTH=8 instance takes the
//   directed vectors and corner sequences; WIDTH=2, 8 and 32 instances are
//   streamed with random operands and compared against plain a+b+cin.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        inValid2, inReady2, outValid2, outReady2, cin2, cout2, busy2;
  logic [1:0]  a2, b2, sum2;
  logic        inValid8, inReady8, outValid8, outReady8, cin8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;
  logic        inValid32, inReady32, outValid32, outReady32, cin32, cout32, busy32;
  logic [31:0] a32, b32, sum32;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  vec_t vecs[8];

  // Free-running clock shared by all instances.
  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(outValid2), .out_ready(outReady2),
    .sum(sum2), .cout(cout2), .busy(busy2)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(outValid8), .out_ready(outReady8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid32), .in_ready(inReady32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(outValid32), .out_ready(outReady32),
    .sum(sum32), .cout(cout32), .busy(busy32)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] aIn,
                               input logic [7:0] bIn, input logic cIn);
    inValid8 = v;
    a8       = aIn;
    b8       = bIn;
    cin8     = cIn;
  endtask

  // Waits (bounded) for out_valid on the WIDTH=8 instance; returns the
  // number of negedges waited.
  task automatic waitDone8(output int n);
    n = 0;
    while (!outValid8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!outValid8) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: out_valid never rose, got 0, expected 1");
    end
  endtask

  // One full transaction on the WIDTH=8 instance with latency and hold checks.
  task automatic runOp8(input string tag, input logic [7:0] aIn, input logic [7:0] bIn,
                        input logic cIn, input logic [7:0] expSum, input logic expCout);
    logic [8:0] prevResult;
    int n;
    prevResult = {cout8, sum8};
    @(negedge clk);
    applyStimulus(1'b1, aIn, bIn, cIn);
    outReady8 = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, $urandom, $urandom, 1'b0);
    checkOutput({tag, " busy after accept"}, 64'(busy8), 64'd1);
    checkOutput({tag, " in_ready in RUN"}, 64'(inReady8), 64'd0);
    checkOutput({tag, " result held in RUN"}, 64'({cout8, sum8}), 64'(prevResult));
    waitDone8(n);
    checkOutput({tag, " latency"}, 64'(n), 64'd8);
    checkOutput({tag, " sum"}, 64'(sum8), 64'(expSum));
    checkOutput({tag, " cout"}, 64'(cout8), 64'(expCout));
    outReady8 = 1'b1;
    @(negedge clk);
    outReady8 = 1'b0;
    checkOutput({tag, " in_ready after handshake"}, 64'(inReady8), 64'd1);
    checkOutput({tag, " out_valid after handshake"}, 64'(outValid8), 64'd0);
    checkOutput({tag, " result held in IDLE"}, 64'({cout8, sum8}), 64'({expCout, expSum}));
  endtask

  function automatic logic [32:0] getResult(input int w);
    case (w)
      2:       return {30'd0, cout2, sum2};
      8:       return {24'd0, cout8, sum8};
      default: return {cout32, sum32};
    endcase
  endfunction

  function automatic logic getInReady(input int w);
    case (w)
      2:       return inReady2;
      8:       return inReady8;
      default: return inReady32;
    endcase
  endfunction

  function automatic logic getOutValid(input int w);
    case (w)
      2:       return outValid2;
      8:       return outValid8;
      default: return outValid32;
    endcase
  endfunction

  task automatic driveStream(input int w, input logic v, input logic [31:0] aIn,
                             input logic [31:0] bIn, input logic cIn);
    case (w)
      2: begin
        inValid2 = v; outReady2 = 1'b1; a2 = aIn[1:0]; b2 = bIn[1:0]; cin2 = cIn;
      end
      8: begin
        inValid8 = v; outReady8 = 1'b1; a8 = aIn[7:0]; b8 = bIn[7:0]; cin8 = cIn;
      end
      default: begin
        inValid32 = v; outReady32 = 1'b1; a32 = aIn; b32 = bIn; cin32 = cIn;
      end
    endcase
  endtask

  // Streams random operands with in_valid and out_ready tied high. The
  // reference is plain a+b+cin at the instance width, queued in accept order.
  task automatic streamRun(input int w, input int nOps);
    logic [32:0] expQ[$];
    logic [32:0] expected;
    logic [31:0] mask;
    logic [31:0] curA, curB;
    logic        curCin;
    int cyc, lastAcc, done, limit;
    cyc     = 0;
    lastAcc = -1;
    done    = 0;
    limit   = nOps * (w + 2) + 200;
    mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    @(negedge clk);
    while (done < nOps && cyc < limit) begin
      curA   = $urandom;
      curB   = $urandom;
      curCin = 1'($urandom_range(0, 1));
      driveStream(w, 1'b1, curA, curB, curCin);
      if (getOutValid(w)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stream w=%0d unexpected result: got 0x%0h, expected none", w, getResult(w));
        end else begin
          expected = expQ.pop_front();
          checkOutput($sformatf("stream w=%0d result", w), 64'(getResult(w)), 64'(expected));
        end
        done++;
      end
      if (getInReady(w)) begin
        if (lastAcc >= 0)
          checkOutput($sformatf("stream w=%0d accept spacing", w), 64'(cyc - lastAcc), 64'(w + 2));
        lastAcc = cyc;
        expQ.push_back({1'b0, curA & mask} + {1'b0, curB & mask} + 33'(curCin));
      end
      @(negedge clk);
      cyc++;
    end
    if (done < nOps) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream w=%0d timeout: got %0d results, expected %0d", w, done, nOps);
    end
    driveStream(w, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int n;
    int seenValid;
    logic [8:0] held;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b1, 8'h09, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    // Reset held for two edges while operands are offered.
    rst = 1'b1;
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b1);
    outReady8 = 1'b0;
    driveStream(2, 1'b0, 32'd0, 32'd0, 1'b0);
    driveStream(32, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 64'(inReady8), 64'd1);
    checkOutput("reset out_valid", 64'(outValid8), 64'd0);
    checkOutput("reset busy", 64'(busy8), 64'd0);
    checkOutput("reset sum", 64'(sum8), 64'd0);
    checkOutput("reset cout", 64'(cout8), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("no accept during reset", 64'(busy8), 64'd0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++)
      runOp8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].expSum, vecs[i].expCout);

    // Backpressure: DONE is held with new operands offered.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    waitDone8(n);
    checkOutput("bp first result", 64'({cout8, sum8}), 64'h046);
    applyStimulus(1'b1, 8'hC8, 8'h64, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid held", 64'(outValid8), 64'd1);
      checkOutput("bp in_ready low", 64'(inReady8), 64'd0);
      checkOutput("bp result stable", 64'({cout8, sum8}), 64'h046);
    end
    outReady8 = 1'b1;
    @(negedge clk);
    outReady8 = 1'b0;
    checkOutput("bp idle after release", 64'(inReady8), 64'd1);
    checkOutput("bp out_valid dropped", 64'(outValid8), 64'd0);
    @(negedge clk);
    checkOutput("bp new operands accepted", 64'(busy8), 64'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    waitDone8(n);
    checkOutput("bp second result", 64'({cout8, sum8}), 64'({1'b0, 8'hC8} + {1'b0, 8'h64} + 9'd1));
    outReady8 = 1'b1;
    @(negedge clk);
    outReady8 = 1'b0;

    // Reset after the 4th RUN edge aborts the operation.
    $display("[TB] reset mid-RUN");
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    outReady8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun in_ready", 64'(inReady8), 64'd1);
    checkOutput("midrun busy", 64'(busy8), 64'd0);
    checkOutput("midrun result cleared", 64'({cout8, sum8}), 64'd0);
    seenValid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (outValid8) seenValid++;
    end
    outReady8 = 1'b0;
    checkOutput("midrun no out_valid", 64'(seenValid), 64'd0);
    held = {cout8, sum8};
    checkOutput("midrun result still cleared", 64'(held), 64'd0);
    runOp8("post-reset", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);

    $display("[TB] streaming");
    streamRun(2, 1000);
    streamRun(8, 1000);
    streamRun(32, 1000);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
